fetch_decode_buffer: RTL

- IF/ID pipeline buffer between the Fetch stage and the Decode stage.
- Consumes the 16-bit instruction word stream and PC values from Fetch.
- Pairs two-word instructions (opcode word followed by a 16-bit immediate word) into one decode packet.
- Presents Decode with a registered {instruction, immediate, pc, next pc, valid} packet; honours stall and flush (branch taken / interrupt entry).

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/imm_opcode_detect.sv | 24 ++
 rtl/fetch_decode_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared IF/ID definitions: word widths, immediate-opcode
// encodings and the fetch/decode buffer state encoding.
package pipeline_pkg;

    localparam int IW_DEF   = 16;
    localparam int PC_W_DEF = 32;

    localparam logic [15:0] NOP_WORD = 16'h0000;

    localparam logic [4:0] OP_IADD = 5'b01101;
    localparam logic [4:0] OP_LDM  = 5'b10001;
    localparam logic [4:0] OP_LDD  = 5'b10010;
    localparam logic [4:0] OP_STD  = 5'b10011;

    typedef enum logic {
        ST_WORD1    = 1'b0,
        ST_WAIT_IMM = 1'b1
    } fdb_state_e;

endpackage

// File: rtl/imm_opcode_detect.sv
// Flags opcodes that are followed by a 16-bit immediate word.
// Purely combinational so Decode can reuse it.
module imm_opcode_detect
    import pipeline_pkg::*;
(
    input  logic [15:0] instr,
    output logic        needs_imm
);

    logic [4:0] op;
    assign op = instr[15:11];

    always_comb begin
        needs_imm = 1'b0;
        unique case (op)
            OP_IADD,
            OP_LDM,
            OP_LDD,
            OP_STD:  needs_imm = 1'b1;
            default: needs_imm = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF/ID buffer: pairs opcode+immediate words into one
// registered decode packet, with stall and flush.
module fetch_decode_buffer
    import pipeline_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int          IW       = IW_DEF,
    parameter logic [15:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [IW-1:0]   instr_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic [PC_W-1:0] next_pc_in,
    output logic [IW-1:0]   instr_out,
    output logic [IW-1:0]   imm_out,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] next_pc_out,
    output logic            valid_out,
    output logic            imm_pending
);

    fdb_state_e      state_q, state_d;
    logic [IW-1:0]   held_instr_q, held_instr_d;
    logic [PC_W-1:0] held_pc_q, held_pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [IW-1:0]   imm_q, imm_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] npc_q, npc_d;
    logic            valid_q, valid_d;
    logic            needs_imm;

    imm_opcode_detect u_detect (
        .instr     (instr_in[15:0]),
        .needs_imm (needs_imm)
    );

    always_comb begin
        state_d      = state_q;
        held_instr_d = held_instr_q;
        held_pc_d    = held_pc_q;
        instr_d      = instr_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        valid_d      = valid_q;

        if (flush) begin
            state_d      = ST_WORD1;
            held_instr_d = '0;
            held_pc_d    = '0;
            instr_d      = NOP_WORD[IW-1:0];
            imm_d        = '0;
            valid_d      = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                ST_WORD1: begin
                    valid_d = 1'b0;
                    instr_d = NOP_WORD[IW-1:0];
                    imm_d   = '0;
                    if (in_valid && needs_imm) begin
                        held_instr_d = instr_in;
                        held_pc_d    = pc_in;
                        state_d      = ST_WAIT_IMM;
                    end else if (in_valid) begin
                        instr_d = instr_in;
                        pc_d    = pc_in;
                        npc_d   = next_pc_in;
                        valid_d = 1'b1;
                    end
                end
                ST_WAIT_IMM: begin
                    valid_d = 1'b0;
                    // Second word is data only, never re-decoded
                    if (in_valid) begin
                        instr_d = held_instr_q;
                        imm_d   = instr_in;
                        pc_d    = held_pc_q;
                        npc_d   = next_pc_in;
                        valid_d = 1'b1;
                        state_d = ST_WORD1;
                    end
                end
                default: state_d = ST_WORD1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_WORD1;
            held_instr_q <= '0;
            held_pc_q    <= '0;
            instr_q      <= NOP_WORD[IW-1:0];
            imm_q        <= '0;
            pc_q         <= '0;
            npc_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_instr_q <= held_instr_d;
            held_pc_q    <= held_pc_d;
            instr_q      <= instr_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            valid_q      <= valid_d;
        end
    end

    assign instr_out   = instr_q;
    assign imm_out     = imm_q;
    assign pc_out      = pc_q;
    assign next_pc_out = npc_q;
    assign valid_out   = valid_q;
    assign imm_pending = (state_q == ST_WAIT_IMM);

endmodule
